// File: rtl/exp_avg_mc_if.sv
// Sample, clear and result bundle for exp_avg_mc; master drives samples/clears,
// slave (the filter) drives the result strobe.
interface exp_avg_mc_if #(
  parameter int W  = 16,
  parameter int CH = 4
);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int KW = $clog2(W);

  logic                 in_valid;
  logic [CW-1:0]        in_ch;
  logic signed [W-1:0]  d;
  logic [KW-1:0]        k;
  logic [W-1:0]         alpha;
  logic                 clr_valid;
  logic [CW-1:0]        clr_ch;
  logic                 out_valid;
  logic [CW-1:0]        out_ch;
  logic signed [W-1:0]  q;

  modport master (
    output in_valid, in_ch, d, k, alpha, clr_valid, clr_ch,
    input  out_valid, out_ch, q
  );
  modport slave (
    input  in_valid, in_ch, d, k, alpha, clr_valid, clr_ch,
    output out_valid, out_ch, q
  );
endinterface

// File: rtl/exp_avg_mc.sv
// Time-multiplexed exponential averager: y += alpha*(x - y) per channel over one
// shared 3-stage datapath, with clear, optional preload and output saturation.
module exp_avg_mc_ch #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic         clr,
  input  logic [W-1:0] wr_y,
  output logic [W-1:0] y,
  output logic         primed
);
  // Clear beats a same-edge write.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      y      <= '0;
      primed <= 1'b0;
    end else if (wr) begin
      y      <= wr_y;
      primed <= 1'b1;
    end
  end
endmodule

module exp_avg_mc #(
  parameter int W       = 16,
  parameter int CH      = 4,
  parameter int MODE    = 0,
  parameter int PRELOAD = 0
) (
  input logic         clk,
  input logic         reset,
  exp_avg_mc_if.slave bus
);
  localparam int CW     = (CH > 1) ? $clog2(CH) : 1;
  localparam int KW     = $clog2(W);
  localparam int STAGES = 2;
  localparam logic signed [W+1:0] SMAX = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] SMIN = {3'b111, {(W-1){1'b0}}};

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [W-1:0]  d;
    logic [KW-1:0] k;
    logic [W-1:0]  alpha;
  } s1_t;

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [W-1:0]  d;
    logic [W:0]    p;
    logic [W-1:0]  y_prev;
    logic          pre;
  } s2_t;

  logic [STAGES:0]        vld_pipe;
  s1_t                    s1;
  s2_t                    s2;
  logic [CH-1:0][W-1:0]   y_st;
  logic [CH-1:0]          primed_st;
  logic [CW-1:0]          q_ch;
  logic [W-1:0]           q_r;
  logic                   acc, fwd, fwd_clr, pr_rd;
  logic signed [W-1:0]    y_rd;
  logic signed [W:0]      diff, p_nx;
  logic signed [2*W+1:0]  prod;
  logic signed [W+1:0]    sum;
  logic [W-1:0]           res;

  assign acc = bus.in_valid && (int'(bus.in_ch) < CH);

  // S3: saturated sum, also the forwarding source for S2.
  always_comb begin
    sum = {{2{s2.y_prev[W-1]}}, s2.y_prev} + {s2.p[W], s2.p};
    res = sum[W-1:0];
    if (sum > SMAX)      res = SMAX[W-1:0];
    else if (sum < SMIN) res = SMIN[W-1:0];
    if (s2.pre)          res = s2.d;
  end

  // S2: state read with S3 bypass; a clear on S3's channel kills the bypass.
  always_comb begin
    fwd     = vld_pipe[1] && (s2.ch == s1.ch);
    fwd_clr = fwd && bus.clr_valid && (bus.clr_ch == s2.ch);
    y_rd    = y_st[s1.ch];
    pr_rd   = primed_st[s1.ch];
    if (fwd_clr) begin
      y_rd  = '0;
      pr_rd = 1'b0;
    end else if (fwd) begin
      y_rd  = res;
      pr_rd = 1'b1;
    end
    diff = {s1.d[W-1], s1.d} - {y_rd[W-1], y_rd};
    prod = diff * $signed({1'b0, s1.alpha});
    if (MODE == 0) p_nx = diff >>> s1.k;
    else           p_nx = (W+1)'(prod >>> (W-1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
      q_r      <= '0;
      q_ch     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], acc};
      if (acc)
        s1 <= '{ch: bus.in_ch, d: bus.d, k: bus.k, alpha: bus.alpha};
      if (vld_pipe[0])
        s2 <= '{ch: s1.ch, d: s1.d, p: p_nx, y_prev: y_rd,
                pre: (PRELOAD != 0) && !pr_rd};
      if (vld_pipe[1]) begin
        q_r  <= res;
        q_ch <= s2.ch;
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    exp_avg_mc_ch #(.W(W)) u_ch (
      .clk    (clk),
      .reset  (reset),
      .wr     (vld_pipe[1] && (int'(s2.ch) == g)),
      .clr    (bus.clr_valid && (int'(bus.clr_ch) == g)),
      .wr_y   (res),
      .y      (y_st[g]),
      .primed (primed_st[g])
    );
  end

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out_ch    = q_ch;
  assign bus.q         = q_r;
endmodule

// File: tb/tb_exp_avg_mc.sv
// Three filters (shift, multiply, shift+preload) fed the same stimulus and checked
// every cycle against a serial per-channel model, plus hand-computed sequences.
module tb_exp_avg_mc;
  localparam int W  = 16;
  localparam int CH = 5;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int KW = $clog2(W);
  localparam int NI = 3;
  localparam longint MAXV = (longint'(1) << (W-1)) - 1;
  localparam longint MINV = -(longint'(1) << (W-1));

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                in_valid, clr_valid;
  logic [CW-1:0]       in_ch, clr_ch;
  logic signed [W-1:0] d;
  logic [KW-1:0]       k;
  logic [W-1:0]        alpha;

  logic                ov[NI];
  logic [CW-1:0]       oc[NI];
  logic signed [W-1:0] oq[NI];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int logq[NI][$];
  int logc[NI][$];

  exp_avg_mc_if #(.W(W), .CH(CH)) bi[NI] ();

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign bi[g].in_valid  = in_valid;
    assign bi[g].in_ch     = in_ch;
    assign bi[g].d         = d;
    assign bi[g].k         = k;
    assign bi[g].alpha     = alpha;
    assign bi[g].clr_valid = clr_valid;
    assign bi[g].clr_ch    = clr_ch;
    assign ov[g]           = bi[g].out_valid;
    assign oc[g]           = bi[g].out_ch;
    assign oq[g]           = bi[g].q;
    exp_avg_mc #(.W(W), .CH(CH), .MODE(g == 1 ? 1 : 0), .PRELOAD(g == 2 ? 1 : 0)) u_dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bi[g])
    );
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    longint r;
    r = a / b;
    if ((a % b) != 0 && a < 0) r--;
    return r;
  endfunction

  // y + alpha*(x - y), alpha = 2^-k or a/2^(W-1), floored, then clamped.
  function automatic longint filt(input int mode, input int pre, input longint y, input bit pr,
                                  input longint x, input int kk, input longint aa);
    longint p, s;
    if (pre != 0 && !pr) return x;
    if (mode == 0) p = fdiv(x - y, longint'(1) << kk);
    else           p = fdiv((x - y) * aa, longint'(1) << (W-1));
    s = y + p;
    if (s > MAXV) s = MAXV;
    if (s < MINV) s = MINV;
    return s;
  endfunction

  // Serial model: a sample computes one edge after capture, after that edge's clear.
  longint my[NI][CH];
  bit     mpr[NI][CH];
  bit     p1v;
  int     p1ch, p1k;
  longint p1d, p1a;
  bit     p2v[NI], ev[NI];
  int     p2ch[NI], ech[NI];
  longint p2q[NI], eq[NI];

  initial begin
    p1v = 0; p1ch = 0; p1k = 0; p1d = 0; p1a = 0;
    for (int i = 0; i < NI; i++) begin
      p2v[i] = 0; ev[i] = 0; p2ch[i] = 0; ech[i] = 0; p2q[i] = 0; eq[i] = 0;
      for (int c = 0; c < CH; c++) begin my[i][c] = 0; mpr[i][c] = 0; end
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < NI; i++) begin
        if (rst) begin
          for (int c = 0; c < CH; c++) begin my[i][c] = 0; mpr[i][c] = 0; end
          p2v[i] = 0; ev[i] = 0; eq[i] = 0; ech[i] = 0;
        end else begin
          ev[i] = p2v[i];
          if (p2v[i]) begin eq[i] = p2q[i]; ech[i] = p2ch[i]; end
          if (clr_valid && clr_ch < CH) begin my[i][clr_ch] = 0; mpr[i][clr_ch] = 0; end
          p2v[i] = p1v;
          if (p1v) begin
            p2q[i]  = filt(i == 1 ? 1 : 0, i == 2 ? 1 : 0, my[i][p1ch], mpr[i][p1ch], p1d, p1k, p1a);
            p2ch[i] = p1ch;
            my[i][p1ch]  = p2q[i];
            mpr[i][p1ch] = 1;
          end
        end
      end
      p1v  = !rst && in_valid && (in_ch < CH);
      p1ch = int'(in_ch);
      p1d  = longint'(d);
      p1k  = int'(k);
      p1a  = longint'(alpha);
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("out_valid[%0d]", i), longint'(ov[i]), longint'(ev[i]));
        chk($sformatf("out_ch[%0d]", i), longint'(oc[i]), longint'(ech[i]));
        chk($sformatf("q[%0d]", i), longint'(oq[i]), eq[i]);
        if (ov[i]) begin logq[i].push_back(int'(oq[i])); logc[i].push_back(cyc); end
      end
    end
  end

  task automatic step(input logic iv, input int ch, input int dd, input int kk, input int aa,
                      input logic cv, input int cc);
    in_valid = iv; in_ch = CW'(ch); d = W'(dd); k = KW'(kk); alpha = W'(aa);
    clr_valid = cv; clr_ch = CW'(cc);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 0, 0, 0, 1'b0, 0);
  endtask

  task automatic clr_logs();
    for (int i = 0; i < NI; i++) begin logq[i].delete(); logc[i].delete(); end
  endtask

  task automatic chk_log(input int i, input string nm, input int e[$]);
    chk({nm, "_count"}, logq[i].size(), e.size());
    for (int j = 0; j < e.size() && j < logq[i].size(); j++)
      chk($sformatf("%s_%0d", nm, j), logq[i][j], e[j]);
  endtask

  int lit_s[$]  = {1000, 1875, 2640, -1000, -1875, -2641};
  int lit_sp[$] = {8000, 8000, 8000, -8000, -8000, -8000};
  int lit_c0[$] = {625, 1171, 100, 200};
  int lit_cp[$] = {5000, 5000, 800, 812};
  int lit_k0[$] = {-32768, 32767};
  int lit_none[$];
  int lit_r[$]  = {1000};
  int lit_rp[$] = {8000};
  int tbl_a[$]  = {8000, -3000, 4000, 12000, -20000, 500, 32767, -32768};
  int tbl_b[$]  = {-8000, 100, 7000};
  int tbl_c[$]  = {30000, 30000, -1234, -32768, 555, 9999};
  int t0;

  initial begin
    rst = 1'b1;
    in_valid = 0; in_ch = '0; d = '0; k = '0; alpha = '0; clr_valid = 0; clr_ch = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("reset_q", longint'(oq[i]), 0);
      chk("reset_out_valid", longint'(ov[i]), 0);
      chk("reset_out_ch", longint'(oc[i]), 0);
    end
    rst = 1'b0;
    idle(2);

    // Step responses, positive and negative, k=3 / alpha=1/8.
    clr_logs();
    t0 = cyc;
    repeat (3) step(1'b1, 0, 8000, 3, 'h1000, 1'b0, 0);
    idle(4);
    repeat (3) step(1'b1, 1, -8000, 3, 'h1000, 1'b0, 0);
    idle(5);
    chk_log(0, "shift_step", lit_s);
    chk_log(1, "mult_step", lit_s);
    chk_log(2, "preload_step", lit_sp);
    if (logc[0].size() > 0) chk("latency", logc[0][0] - t0, 3);

    // Interleaved channels, back-to-back repeats, non-power-of-two alpha.
    clr_logs();
    for (int j = 0; j < 8; j++) step(1'b1, (j % 2) ? 2 : 0, tbl_a[j], 3, 'h1000, 1'b0, 0);
    for (int j = 0; j < 3; j++) step(1'b1, 0, tbl_b[j], 3, 'h1000, 1'b0, 0);
    for (int j = 0; j < 6; j++) step(1'b1, (j % 3 == 0) ? 4 : 2, tbl_c[j], 2, 'h5555, 1'b0, 0);
    idle(5);
    for (int i = 0; i < NI; i++) chk("interleave_count", logq[i].size(), 17);

    // Clear coincident with ch3's S3 write while the next ch3 sample sits in S2.
    clr_logs();
    step(1'b1, 3, 5000, 3, 'h1000, 1'b0, 0);
    step(1'b1, 3, 5000, 3, 'h1000, 1'b0, 0);
    step(1'b1, 3, 800, 3, 'h1000, 1'b0, 0);
    step(1'b0, 0, 0, 0, 0, 1'b1, 3);
    idle(2);
    step(1'b1, 3, 900, 3, 'h1000, 1'b0, 0);
    idle(5);
    chk_log(0, "clear_shift", lit_c0);
    chk_log(2, "clear_preload", lit_cp);

    // Full-scale jump at alpha=1, then out-of-range channels.
    clr_logs();
    step(1'b1, 1, -32768, 0, 'h8000, 1'b0, 0);
    step(1'b1, 1, 32767, 0, 'h8000, 1'b0, 0);
    step(1'b1, 6, 1234, 3, 'h1000, 1'b0, 0);
    step(1'b1, 7, -1234, 3, 'h1000, 1'b0, 0);
    idle(5);
    for (int i = 0; i < NI; i++) chk_log(i, $sformatf("alpha_one_%0d", i), lit_k0);

    // Reset with three samples in flight.
    clr_logs();
    step(1'b1, 0, 100, 3, 'h1000, 1'b0, 0);
    step(1'b1, 0, 200, 3, 'h1000, 1'b0, 0);
    rst = 1'b1;
    step(1'b1, 0, 300, 3, 'h1000, 1'b0, 0);
    rst = 1'b0;
    idle(4);
    for (int i = 0; i < NI; i++) begin
      chk_log(i, $sformatf("flushed_%0d", i), lit_none);
      chk("flushed_q", longint'(oq[i]), 0);
    end
    step(1'b1, 0, 8000, 3, 'h1000, 1'b0, 0);
    idle(5);
    chk_log(0, "after_reset_shift", lit_r);
    chk_log(1, "after_reset_mult", lit_r);
    chk_log(2, "after_reset_preload", lit_rp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
